// File: rtl/crc32_engine_pkg.sv
// Shared CRC-32 definitions: polynomial, register map, FSM encoding, response codes
// and the single-bit LFSR step used by the fold logic.
package crc32_engine_pkg;

  localparam logic [31:0] CRC32_POLY  = 32'h04C1_1DB7;

  localparam logic [7:0]  CRC_INITIAL = 8'h00;
  localparam logic [7:0]  CRC_DATA    = 8'h04;
  localparam logic [7:0]  CRC_RESULT  = 8'h08;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } crc_state_e;

  // One message bit shifted into a normal-form (MSB-first) CRC-32 register.
  function automatic logic [31:0] crc_bit_step(input logic [31:0] crc,
                                               input logic        d,
                                               input logic [31:0] poly);
    logic fb;
    fb = crc[31] ^ d;
    return {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/crc32_step.sv
// Combinational fold of BITS_PER_CYCLE message bits (MSB first) into a running CRC.
module crc32_step
  import crc32_engine_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] POLY           = CRC32_POLY,
  parameter int          BITS_PER_CYCLE = 8
) (
  input  logic [DATA_WIDTH-1:0]     crc_in,
  input  logic [BITS_PER_CYCLE-1:0] data_in,
  output logic [DATA_WIDTH-1:0]     crc_out
);

  logic [DATA_WIDTH-1:0] w_acc;

  // Unrolled bit-serial chain; data_in[MSB] is the oldest bit.
  always_comb begin
    w_acc = crc_in;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      w_acc = crc_bit_step(w_acc, data_in[i], POLY);
    end
    crc_out = w_acc;
  end

endmodule

// File: rtl/crc32_engine.sv
// Multi-cycle CRC-32 core: seeds from crc_initial, folds crc_data words
// BITS_PER_CYCLE bits per clock and publishes crc_result with a done pulse.
module crc32_engine
  import crc32_engine_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] POLY           = CRC32_POLY,
  parameter int          BITS_PER_CYCLE = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  init_load,
  input  logic [DATA_WIDTH-1:0] crc_initial,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] crc_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [DATA_WIDTH-1:0] crc_result
);

  localparam int STEPS = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] COUNT_LOAD = CW'(STEPS - 1);

  crc_state_e            r_state;
  crc_state_e            w_next_state;
  logic [DATA_WIDTH-1:0] r_crc;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_count;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_crc_result;
  logic [DATA_WIDTH-1:0] w_step_crc;
  logic [DATA_WIDTH-1:0] w_shift_next;

  crc32_step #(
    .DATA_WIDTH     (DATA_WIDTH),
    .POLY           (POLY),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .crc_in  (r_crc),
    .data_in (r_shift[DATA_WIDTH-1 -: BITS_PER_CYCLE]),
    .crc_out (w_step_crc)
  );

  // A full-width fold consumes the whole word in one step, leaving nothing to shift.
  if (BITS_PER_CYCLE < DATA_WIDTH) begin : g_shift
    assign w_shift_next = {r_shift[DATA_WIDTH-BITS_PER_CYCLE-1:0], {BITS_PER_CYCLE{1'b0}}};
  end else begin : g_noshift
    assign w_shift_next = {DATA_WIDTH{1'b0}};
  end

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_count == {CW{1'b0}}) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_CALC;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and registered status; a start/init_load while busy never touches r_crc or r_shift.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_crc        <= {DATA_WIDTH{1'b0}};
      r_shift      <= {DATA_WIDTH{1'b0}};
      r_count      <= {CW{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_crc_result <= {DATA_WIDTH{1'b0}};
    end else begin
      r_busy    <= (w_next_state != S_IDLE);
      r_done    <= (r_state == S_DONE);
      r_overrun <= start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (init_load) begin
            r_crc <= crc_initial;
          end
          if (start) begin
            r_shift <= crc_data;
            r_count <= COUNT_LOAD;
          end
        end
        S_CALC: begin
          r_crc   <= w_step_crc;
          r_shift <= w_shift_next;
          if (r_count != {CW{1'b0}}) begin
            r_count <= r_count - CW'(1);
          end
        end
        S_DONE: begin
          r_crc_result <= r_crc;
        end
        default: begin
          r_crc <= r_crc;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign crc_result = r_crc_result;

endmodule

// File: tb/tb_crc32_engine.sv
// Directed and randomised checks of crc32_engine at BITS_PER_CYCLE 8 (main), 1 and 32.
module tb_crc32_engine;

  localparam logic [31:0] P = 32'h04C1_1DB7;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        init_load = 1'b0;
  logic [31:0] crc_initial = 32'h0;
  logic        start = 1'b0;
  logic [31:0] crc_data = 32'h0;

  logic        busy8, done8, ovr8;
  logic [31:0] res8;
  logic        busy1, done1, ovr1;
  logic [31:0] res1;
  logic        busy32, done32, ovr32;
  logic [31:0] res32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  crc32_engine #(.DATA_WIDTH(32), .POLY(P), .BITS_PER_CYCLE(8)) u_dut (
    .ACLK(ACLK), .ARESET(ARESET), .init_load(init_load), .crc_initial(crc_initial),
    .start(start), .crc_data(crc_data), .busy(busy8), .done(done8),
    .overrun(ovr8), .crc_result(res8));

  crc32_engine #(.DATA_WIDTH(32), .POLY(P), .BITS_PER_CYCLE(1)) u_dut1 (
    .ACLK(ACLK), .ARESET(ARESET), .init_load(init_load), .crc_initial(crc_initial),
    .start(start), .crc_data(crc_data), .busy(busy1), .done(done1),
    .overrun(ovr1), .crc_result(res1));

  crc32_engine #(.DATA_WIDTH(32), .POLY(P), .BITS_PER_CYCLE(32)) u_dut32 (
    .ACLK(ACLK), .ARESET(ARESET), .init_load(init_load), .crc_initial(crc_initial),
    .start(start), .crc_data(crc_data), .busy(busy32), .done(done32),
    .overrun(ovr32), .crc_result(res32));

  // Word-at-a-time form: XOR the word in, then 32 plain LFSR shifts.
  function automatic logic [31:0] ref_crc(input logic [31:0] seed, input logic [31:0] data);
    logic [31:0] c;
    c = seed ^ data;
    for (int k = 0; k < 32; k++) begin
      c = c[31] ? ((c << 1) ^ P) : (c << 1);
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] seed);
    init_load = 1'b1; crc_initial = seed;
    tick();
    init_load = 1'b0;
  endtask

  task automatic start_word(input logic [31:0] d);
    start = 1'b1; crc_data = d;
    tick();
    start = 1'b0;
  endtask

  // Called just after the start edge T: checks busy/done timing and the T+5 result.
  task automatic expect_word(input string tag, input logic [31:0] exp);
    tick();
    chk({tag, "_busy_t1"}, {31'd0, busy8}, 32'd1);
    tick(); tick(); tick();
    chk({tag, "_done_t4"}, {31'd0, done8}, 32'd0);
    tick();
    chk({tag, "_done_t5"}, {31'd0, done8}, 32'd1);
    chk({tag, "_result"}, res8, exp);
    chk({tag, "_busy_t5"}, {31'd0, busy8}, 32'd0);
    tick();
    chk({tag, "_done_t6"}, {31'd0, done8}, 32'd0);
  endtask

  initial begin
    int          lat8, lat1, lat32, n_done;
    logic [31:0] seed, data, exp;

    tick(); tick();
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_ovr", {31'd0, ovr8}, 32'd0);
    chk("rst_result", res8, 32'd0);
    ARESET = 1'b0;
    tick();

    load(32'h0); start_word(32'h0);
    expect_word("zero", 32'h0000_0000);

    load(32'h0); start_word(32'h0000_0001);
    expect_word("impulse1", 32'h04C1_1DB7);
    load(32'h0); start_word(32'h0000_0002);
    expect_word("impulse2", 32'h0982_3B6E);

    load(32'h0000_0001); start_word(32'h0);
    expect_word("seed_only", 32'h04C1_1DB7);
    load(32'hA5A5_1234); start_word(32'hA5A5_1234);
    expect_word("seed_eq_data", 32'h0000_0000);

    // Start + init_load during CALC must both be ignored; only overrun reacts.
    load(32'h0); start_word(32'h0000_0001);
    start = 1'b1; crc_data = 32'hFFFF_FFFF; init_load = 1'b1; crc_initial = 32'h1234_5678;
    tick();
    start = 1'b0; init_load = 1'b0;
    chk("overrun_pulse", {31'd0, ovr8}, 32'd1);
    tick();
    chk("overrun_clear", {31'd0, ovr8}, 32'd0);
    tick(); tick();
    chk("overrun_done_t4", {31'd0, done8}, 32'd0);
    tick();
    chk("overrun_done_t5", {31'd0, done8}, 32'd1);
    chk("overrun_result", res8, 32'h04C1_1DB7);
    tick();

    init_load = 1'b1; crc_initial = 32'hDEAD_BEEF;
    start = 1'b1; crc_data = 32'hDEAD_BEEF;
    tick();
    init_load = 1'b0; start = 1'b0;
    expect_word("same_cycle_seed", 32'h0000_0000);

    load(32'h0); start_word(32'h0000_0001);
    expect_word("chain_w0", 32'h04C1_1DB7);
    start_word(32'h0);
    expect_word("chain_w1", ref_crc(32'h04C1_1DB7, 32'h0));

    start_word(32'h0000_0005);
    tick(); tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    chk("midreset_busy", {31'd0, busy8}, 32'd0);
    chk("midreset_done", {31'd0, done8}, 32'd0);
    chk("midreset_result", res8, 32'd0);
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done8) n_done++;
    end
    chk("midreset_no_done", n_done, 32'd0);

    ARESET = 1'b1; tick(); ARESET = 1'b0; tick();
    for (int it = 0; it < 1000; it++) begin
      seed = $urandom(); data = $urandom();
      exp = ref_crc(seed, data);
      init_load = 1'b1; crc_initial = seed;
      start = 1'b1; crc_data = data;
      tick();
      init_load = 1'b0; start = 1'b0;
      lat8 = -1; lat1 = -1; lat32 = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        tick();
        if (done8  && lat8  < 0) lat8  = cyc;
        if (done1  && lat1  < 0) lat1  = cyc;
        if (done32 && lat32 < 0) lat32 = cyc;
        if (lat8 >= 0 && lat1 >= 0 && lat32 >= 0) break;
      end
      chk("sweep_lat8", lat8, 32'd5);
      chk("sweep_lat1", lat1, 32'd33);
      chk("sweep_lat32", lat32, 32'd2);
      chk("sweep_res8", res8, exp);
      chk("sweep_res1", res1, exp);
      chk("sweep_res32", res32, exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
